peripheral_bus: RTL and testbench

Memory-mapped peripheral responder on the core's data-memory bus: the slave end of the address/read/write/read-data interface plus the interrupt request line into the core. It holds a reloadable timer with interrupt, LED and 7-segment output registers, a switch input and a free-running cycle counter. The top level muxes oMemReadData with data-RAM read data using oHit.

---
 rtl/peripheral_bus.sv | 181 ++++++++++++++++++
 tb/tb_peripheral_bus.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus.sv
// peripheral_bus -- memory-mapped peripheral responder on the core data bus.
//
// Holds a reloadable up-counting timer with interrupt, LED and 7-segment
// output registers, a switch input and an optional free-running cycle counter.
// Reads are combinational so the core can consume them in the same cycle; the
// top level muxes oMemReadData against data-RAM read data using oHit.
//
// Optional feature: define PERIPH_SYSTICK_EN to build the 32-bit SYSTICK
// counter at offset 0x18. Without it, 0x18 is unmapped.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   iMemAddr            byte address (bits [1:0] ignored)
//   iMemRead/iMemWrite  read / write strobes
//   iMemWriteData       write data
//   oMemReadData        read data, 0 unless reading a mapped register
//   oHit                address decodes to a mapped register
//   oInterrupt          TCON[1] & TCON[2]
//   iSwitch             synchronised switch levels
//   oLed, oDigi         LED register, 7-seg register ([11:8] anodes, [7:0] segs)
//
// Register map (word offsets): 0x00 TH, 0x04 TL, 0x08 TCON, 0x0C LED,
// 0x10 SWITCH (RO), 0x14 DIGI, 0x18 SYSTICK (RO, optional), 0x1C unmapped.

module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      iMemAddr,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic [31:0]      iMemWriteData,
    output logic [31:0]      oMemReadData,
    output logic             oHit,
    output logic             oInterrupt,
    input  logic [SW_W-1:0]  iSwitch,
    output logic [LED_W-1:0] oLed,
    output logic [11:0]      oDigi
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SW      = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    logic [31:0]      th_q, th_d;
    logic [31:0]      tl_q, tl_d;
    logic [2:0]       tcon_q, tcon_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [11:0]      digi_q, digi_d;

    logic        in_window;
    logic [2:0]  off;
    logic        mapped;
    logic [31:0] rd_sel;
    logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
    logic        tl_full;
    logic        tmr_run;

    // Byte lane bits are don't-care for word-addressed registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^iMemAddr[1:0];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign in_window = (iMemAddr[31:5] == BASE_ADDR[31:5]);
    assign off       = iMemAddr[4:2];

    always_comb begin
        mapped = 1'b0;
        case (off)
            OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI: mapped = in_window;
`ifdef PERIPH_SYSTICK_EN
            OFF_SYSTICK: mapped = in_window;
`endif
            default: mapped = 1'b0;
        endcase
    end

    assign oHit = mapped;

    // ------------------------------------------------------------------
    // Optional free-running cycle counter
    // ------------------------------------------------------------------
`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) systick_q <= '0;
        else       systick_q <= systick_q + 32'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: registered state only, so a simultaneous write returns
    // the pre-write value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_sel = '0;
        case (off)
            OFF_TH:   rd_sel = th_q;
            OFF_TL:   rd_sel = tl_q;
            OFF_TCON: rd_sel[2:0] = tcon_q;
            OFF_LED:  rd_sel[LED_W-1:0] = led_q;
            OFF_SW:   rd_sel[SW_W-1:0] = iSwitch;
            OFF_DIGI: rd_sel[11:0] = digi_q;
`ifdef PERIPH_SYSTICK_EN
            OFF_SYSTICK: rd_sel = systick_q;
`endif
            default:  rd_sel = '0;
        endcase
    end

    assign oMemReadData = (iMemRead && mapped) ? rd_sel : 32'd0;

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    assign wr_th   = iMemWrite && in_window && (off == OFF_TH);
    assign wr_tl   = iMemWrite && in_window && (off == OFF_TL);
    assign wr_tcon = iMemWrite && in_window && (off == OFF_TCON);
    assign wr_led  = iMemWrite && in_window && (off == OFF_LED);
    assign wr_digi = iMemWrite && in_window && (off == OFF_DIGI);

    // ------------------------------------------------------------------
    // Timer next state
    // ------------------------------------------------------------------
    assign tl_full = &tl_q;

    // A TCON write that clears the enable stops the timer on that very edge
    // (no increment, no reload, no irq). A write that sets the enable only
    // takes effect from the following edge.
    assign tmr_run = tcon_q[0] && !(wr_tcon && !iMemWriteData[0]);

    always_comb begin
        th_d   = wr_th ? iMemWriteData : th_q;

        // Reload reads th_q, so a same-edge TH write only affects later reloads.
        tl_d = tl_q;
        if (tmr_run)
            tl_d = tl_full ? th_q : tl_q + 32'd1;
        if (wr_tl)
            tl_d = iMemWriteData;

        tcon_d = wr_tcon ? iMemWriteData[2:0] : tcon_q;
        // Overflow status set beats a software clear on the same edge.
        if (tmr_run && tl_full && tcon_q[1])
            tcon_d[2] = 1'b1;

        led_d  = wr_led  ? iMemWriteData[LED_W-1:0] : led_q;
        digi_d = wr_digi ? iMemWriteData[11:0]      : digi_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    assign oInterrupt = tcon_q[1] & tcon_q[2];
    assign oLed       = led_q;
    assign oDigi      = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
module tb_peripheral_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef PERIPH_SYSTICK_EN
    localparam bit ST_ON = 1'b1;
`else
    localparam bit ST_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;
    logic        oHit;
    logic        oInterrupt;
    logic [7:0]  sw;
    logic [7:0]  oLed;
    logic [11:0] oDigi;

    peripheral_bus #(.BASE_ADDR(BASE), .LED_W(8), .SW_W(8)) dut (
        .clk(clk), .reset(reset),
        .iMemAddr(iMemAddr), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iMemWriteData(iMemWriteData), .oMemReadData(oMemReadData),
        .oHit(oHit), .oInterrupt(oInterrupt), .iSwitch(sw),
        .oLed(oLed), .oDigi(oDigi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sampled DUT outputs from the latest step (taken mid-cycle).
    logic [31:0] a_rdata;
    logic        a_hit;
    logic        a_irq;

    // ------------------------------------------------------------------
    // Reference model: register file with the timer rules applied per edge.
    // ------------------------------------------------------------------
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    task automatic m_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_systick = 0;
    endtask

    function automatic bit m_mapped(input logic [31:0] a);
        int o;
        if (a[31:5] != BASE[31:5]) return 1'b0;
        o = int'(a[4:2]);
        if (o <= 5) return 1'b1;
        if (o == 6) return ST_ON;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        case (int'(a[4:2]))
            0: return m_th;
            1: return m_tl;
            2: return 32'(m_tcon);
            3: return 32'(m_led);
            4: return 32'(sw);
            5: return 32'(m_digi);
            6: return m_systick;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_edge(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] nth, ntl;
        logic [2:0]  ntcon;
        bit          irq_evt;
        nth = m_th; ntl = m_tl; ntcon = m_tcon; irq_evt = 0;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                ntl = m_th;
                irq_evt = m_tcon[1];
            end else begin
                ntl = m_tl + 1;
            end
        end
        if (wr && m_mapped(a)) begin
            case (int'(a[4:2]))
                0: nth = wd;
                1: ntl = wd;
                2: begin
                    ntcon = wd[2:0];
                    // disabling write cancels this edge's timer activity
                    if (!wd[0]) begin ntl = m_tl; irq_evt = 0; end
                end
                3: m_led = wd[7:0];
                5: m_digi = wd[11:0];
                default: ;
            endcase
        end
        if (irq_evt) ntcon[2] = 1'b1;
        m_th = nth; m_tl = ntl; m_tcon = ntcon;
        if (ST_ON) m_systick = m_systick + 1;
    endtask

    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at edge+1, sample at edge+5, compare with the
    // model, then clock the edge into both DUT and model.
    task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        iMemRead = rd; iMemWrite = wr; iMemAddr = a; iMemWriteData = wd;
        #4;
        a_rdata = oMemReadData; a_hit = oHit; a_irq = oInterrupt;
        check("model_rdata", a_rdata, (rd && m_mapped(a)) ? m_reg(a) : 32'd0);
        check("model_hit", 32'(a_hit), 32'(m_mapped(a)));
        check("model_irq", 32'(a_irq), 32'(m_tcon[1] & m_tcon[2]));
        check("model_led", 32'(oLed), 32'(m_led));
        check("model_digi", 32'(oDigi), 32'(m_digi));
        @(posedge clk);
        m_edge(wr, a, wd);
        #1;
        iMemRead = 0; iMemWrite = 0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
        step(1, 0, BASE + off, 0);
        check(name, a_rdata, exp);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [7:0]  swv;
        logic [31:0] exp_data;
        bit          exp_hit;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] t0;
        reset = 1; sw = 0;
        iMemAddr = 0; iMemRead = 0; iMemWrite = 0; iMemWriteData = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        m_reset();

        // Reset state, decode boundaries, LED/DIGI/SWITCH behaviour.
        vecs.push_back('{1, 0, BASE + 32'h00, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h04, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h08, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h0C, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h10, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h14, 0, 8'h00, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h1C, 0, 8'h00, 32'h0, 0});
        vecs.push_back('{1, 0, BASE + 32'h20, 0, 8'h00, 32'h0, 0});
        vecs.push_back('{1, 0, 32'h3FFF_FFFC, 0, 8'h00, 32'h0, 0});
        vecs.push_back('{0, 1, BASE + 32'h0C, 32'hFFFF_FFA5, 8'h3C, 32'h0, 1});
        vecs.push_back('{0, 1, BASE + 32'h16, 32'h0000_17C0, 8'h3C, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h0D, 0, 8'h3C, 32'h0000_00A5, 1});
        vecs.push_back('{1, 0, BASE + 32'h14, 0, 8'h3C, 32'h0000_07C0, 1});
        vecs.push_back('{1, 0, BASE + 32'h10, 0, 8'h3C, 32'h0000_003C, 1});
        vecs.push_back('{0, 1, BASE + 32'h10, 32'hFF, 8'h3C, 32'h0, 1});
        vecs.push_back('{1, 0, BASE + 32'h10, 0, 8'h3C, 32'h0000_003C, 1});
        vecs.push_back('{0, 0, BASE + 32'h0C, 0, 8'h3C, 32'h0, 1});

        check("reset_irq", 32'(oInterrupt), 32'd0);
        foreach (vecs[i]) begin
            sw = vecs[i].swv;
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d_data", i), a_rdata, vecs[i].exp_data);
            check($sformatf("vec%0d_hit", i), 32'(a_hit), 32'(vecs[i].exp_hit));
        end
        check("led_out", 32'(oLed), 32'h0000_00A5);
        check("digi_out", 32'(oDigi), 32'h0000_07C0);

        // Read and write together: read returns the old value.
        step(1, 1, BASE + 32'h0C, 32'h5A);
        check("rdwr_old", a_rdata, 32'h0000_00A5);
        rd_chk("rdwr_new", 32'h0C, 32'h0000_005A);

        // Timer reload and interrupt.
        step(0, 1, BASE + 32'h00, 32'hFFFF_FFFC);
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
        step(0, 1, BASE + 32'h08, 32'h3);
        rd_chk("tl_fe", 32'h04, 32'hFFFF_FFFE);
        rd_chk("tl_ff", 32'h04, 32'hFFFF_FFFF);
        rd_chk("tl_reload", 32'h04, 32'hFFFF_FFFC);
        check("irq_set", 32'(a_irq), 32'd1);
        rd_chk("tcon_7", 32'h08, 32'h7);
        step(0, 1, BASE + 32'h08, 32'h3);
        rd_chk("tcon_clr", 32'h08, 32'h3);
        check("irq_clr", 32'(a_irq), 32'd0);
        rd_chk("tcon_reovf", 32'h08, 32'h7);

        // Overflow set wins over a same-edge software clear.
        step(0, 1, BASE + 32'h08, 32'h3);
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
        rd_chk("tl_pre_ovf", 32'h04, 32'hFFFF_FFFF);   // this edge overflows (TL FF)
        step(0, 1, BASE + 32'h08, 32'h3);              // TL reloaded already; no ovf here
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
        step(0, 1, BASE + 32'h08, 32'h3);              // clear on the overflow edge
        rd_chk("set_wins", 32'h08, 32'h7);

        // Disabling write on the overflow edge: no reload, status cleared.
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
        step(0, 1, BASE + 32'h08, 32'h2);
        rd_chk("dis_tl", 32'h04, 32'hFFFF_FFFF);
        rd_chk("dis_tcon", 32'h08, 32'h2);

        // TH write on reload edge: reload uses old TH.
        step(0, 1, BASE + 32'h08, 32'h3);
        step(0, 1, BASE + 32'h00, 32'h1234_5678);
        rd_chk("reload_old_th", 32'h04, 32'hFFFF_FFFC);
        rd_chk("th_new", 32'h00, 32'h1234_5678);

        // Software-set interrupt, then async reset between edges.
        step(0, 1, BASE + 32'h08, 32'h6);
        check("sw_irq", 32'(oInterrupt), 32'd1);
        iMemRead = 1; iMemAddr = BASE + 32'h04;
        #2 reset = 1;
        #1;
        check("async_irq", 32'(oInterrupt), 32'd0);
        check("async_tl", oMemReadData, 32'd0);
        @(posedge clk);
        #1 reset = 0; iMemRead = 0;
        m_reset();
        rd_chk("post_rst_tcon", 32'h08, 32'd0);

        // Optional cycle counter.
`ifdef PERIPH_SYSTICK_EN
        rd_chk("systick_a", 32'h18, m_systick);
        t0 = a_rdata;
        repeat (9) step(0, 0, 0, 0);
        step(1, 0, BASE + 32'h18, 0);
        check("systick_delta", a_rdata - t0, 32'd10);
        check("systick_hit", 32'(a_hit), 32'd1);
`else
        t0 = 0;
        step(1, 0, BASE + 32'h18, 0);
        check("systick_off_data", a_rdata + t0, 32'd0);
        check("systick_off_hit", 32'(a_hit), 32'd0);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            int k;
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            k = $urandom_range(0, 3);
            case (int'(a[4:2]))
                0, 1: wd = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'hFFFF_FFFD :
                           (k == 2) ? 32'hFFFF_FFF8 : $urandom();
                2: wd = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 7)) | 32'h1;
                default: wd = $urandom();
            endcase
            if ($urandom_range(0, 50) == 0) sw = 8'($urandom());
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
